axi_lite_ctrl_wrapper: RTL and testbench
========================================

Name: axi_lite_ctrl_wrapper

Overview:
- AXI4-Lite slave register block that configures and launches the matrix compute core.
- Holds the M/K/N dimension registers and generates a single-cycle start pulse.
- Exposes a sticky done/busy status to the host.
- Sits between the host AXI-Lite interconnect and the compute core control ports.

Parameters:
- DATA_W, 32, AXI data width; registers occupy the low 32 bits.
- ADDR_W, 32, AXI address width; only offset bits [7:0] are decoded, upper bits ignored.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_W  write data
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bvalid  out  1  write response valid
- s_axi_bresp  out  2  write response
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_W  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- cfg_m  out  32  M dimension
- cfg_k  out  32  K dimension
- cfg_n  out  32  N dimension
- start  out  1  one-cycle launch pulse to the core
- done  in  1  completion pulse from the core

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, all registers 0, both FSMs in IDLE.
- Register map (byte offsets):
  - 0x00 CTRL: write bit0=1 requests start; reads 0.
  - 0x04 STATUS: read-only. bit0 DONE (sticky), bit1 BUSY, other bits 0. Writes are ignored and return OKAY.
  - 0x08 CFG_M: R/W, drives cfg_m.
  - 0x0C CFG_K: R/W, drives cfg_k.
  - 0x10 CFG_N: R/W, drives cfg_n.
  - Any other offset, including misaligned offsets such as 0x0A, is invalid.
- Write FSM, IDLE -> BRESP:
  - In IDLE, on an edge where awvalid && wvalid are both 1: capture awaddr/wdata and update the target register at that edge.
  - At that same edge, register awready=1 and wready=1 for exactly one cycle, and bvalid=1.
  - The master may drop awvalid/wvalid once it sees awready/wready.
  - If only one of awvalid/wvalid is high: wait, no capture.
  - bvalid and bresp hold until the edge with bready=1; then return to IDLE. The next write can be accepted no earlier than the following edge.
- Start:
  - A CTRL write with wdata[0]=1 arms a start request.
  - start=1 for exactly one cycle, registered at the B-handshake edge.
  - At that same edge: DONE clears, BUSY sets.
  - A CTRL write with bit0=0 has no effect.
- Done:
  - done=1 at an edge sets DONE and clears BUSY.
  - If done and the start-clear occur on the same edge, DONE=1 wins.
  - done is level-sampled every cycle, independent of bus activity.
- Read FSM, IDLE -> RRESP:
  - In IDLE with arvalid=1: capture araddr and register rdata/rresp.
  - At that edge: arready=1 for one cycle, rvalid=1.
  - rvalid, rdata and rresp hold until the rready edge; then return to IDLE.
  - arvalid seen while in RRESP is ignored.
- Invalid addresses:
  - Writes change nothing.
  - Reads return rdata=0.
  - Response codes are set by the optional feature below.
- Read and write FSMs are independent and may operate concurrently.
- Reset mid-transaction: abort immediately, drop all valid/ready signals, clear all registers.

Optional Feature:
- AXI_SLVERR_EN defined: invalid-address accesses return bresp/rresp=2'b10 (SLVERR).
- AXI_SLVERR_EN undefined: invalid-address accesses return 2'b00 (OKAY).
- In both cases, valid accesses return OKAY and invalid accesses never modify state.

Test Plan:
- Write 0x08=4, 0x0C=5, 0x10=6 -> cfg_m=4, cfg_k=5, cfg_n=6, each bresp=00. Readback of each offset returns 4/5/6 with rresp=00.
- Write 0x0A=7 and read 0x0A -> cfg registers unchanged, rdata=0, resp=10 with AXI_SLVERR_EN (00 without).
- Write 0x04=1 -> STATUS still reads 0, bresp=00.
- Write 0x00=1 -> start=1 in the cycle after the B handshake, start=0 the next cycle. STATUS then reads bit1=1, bit0=0.
- Pulse done for one cycle, then read 0x04 -> rdata bit0=1, bit1=0. Write 0x00=1, then read 0x04 -> bit0=0.
- Assert rst_n=0 while bvalid pending -> bvalid, start and all cfg outputs go 0 immediately.

Source files
------------

// File: rtl/axi_lite_ctrl_wrapper.sv
// AXI4-Lite control/status register block that configures and launches the matrix compute core.
// Optional: define AXI_SLVERR_EN to answer invalid offsets with SLVERR instead of OKAY.
module axi_lite_ctrl_wrapper #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [DATA_W-1:0] s_axi_wdata,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic              s_axi_bvalid,
   output logic [1:0]        s_axi_bresp,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [DATA_W-1:0] s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic [31:0]       cfg_m,
   output logic [31:0]       cfg_k,
   output logic [31:0]       cfg_n,
   output logic              start,
   input  logic              done
);

   localparam logic [7:0] OffCtrl   = 8'h00;
   localparam logic [7:0] OffStatus = 8'h04;
   localparam logic [7:0] OffCfgM   = 8'h08;
   localparam logic [7:0] OffCfgK   = 8'h0C;
   localparam logic [7:0] OffCfgN   = 8'h10;
   localparam logic [1:0] RespOkay  = 2'b00;
`ifdef AXI_SLVERR_EN
   localparam logic [1:0] RespInvalid = 2'b10;
`else
   localparam logic [1:0] RespInvalid = 2'b00;
`endif

   typedef enum logic {WrIdle, WrBresp} wrState_t;
   typedef enum logic {RdIdle, RdRresp} rdState_t;

   wrState_t          wrState_q, wrState_d;
   rdState_t          rdState_q, rdState_d;
   logic              awready_q, awready_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              arready_q, arready_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [31:0]       cfgM_q, cfgM_d;
   logic [31:0]       cfgK_q, cfgK_d;
   logic [31:0]       cfgN_q, cfgN_d;
   logic              startPend_q, startPend_d;
   logic              start_q, start_d;
   logic              doneSticky_q, doneSticky_d;
   logic              busy_q, busy_d;

   logic [7:0]        wrOff;
   logic [7:0]        rdOff;
   logic              wrAccept;
   logic              bHandshake;
   logic              rdAccept;
   logic [31:0]       rdVal;
   logic              unusedAddrBits;

   function automatic logic isValidOff(input logic [7:0] off);
      return (off == OffCtrl) || (off == OffStatus) || (off == OffCfgM) ||
             (off == OffCfgK) || (off == OffCfgN);
   endfunction

   assign wrOff          = s_axi_awaddr[7:0];
   assign rdOff          = s_axi_araddr[7:0];
   assign unusedAddrBits = ^{s_axi_awaddr[ADDR_W-1:8], s_axi_araddr[ADDR_W-1:8]};
   assign wrAccept       = (wrState_q == WrIdle) && s_axi_awvalid && s_axi_wvalid;
   assign bHandshake     = (wrState_q == WrBresp) && s_axi_bready;
   assign rdAccept       = (rdState_q == RdIdle) && s_axi_arvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrState_q    <= WrIdle;
         rdState_q    <= RdIdle;
         awready_q    <= 1'b0;
         bresp_q      <= 2'b00;
         arready_q    <= 1'b0;
         rdata_q      <= '0;
         rresp_q      <= 2'b00;
         cfgM_q       <= '0;
         cfgK_q       <= '0;
         cfgN_q       <= '0;
         startPend_q  <= 1'b0;
         start_q      <= 1'b0;
         doneSticky_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         wrState_q    <= wrState_d;
         rdState_q    <= rdState_d;
         awready_q    <= awready_d;
         bresp_q      <= bresp_d;
         arready_q    <= arready_d;
         rdata_q      <= rdata_d;
         rresp_q      <= rresp_d;
         cfgM_q       <= cfgM_d;
         cfgK_q       <= cfgK_d;
         cfgN_q       <= cfgN_d;
         startPend_q  <= startPend_d;
         start_q      <= start_d;
         doneSticky_q <= doneSticky_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      wrState_d = wrState_q;
      rdState_d = rdState_q;
      case (wrState_q)
         WrIdle:  if (wrAccept) wrState_d = WrBresp;
         WrBresp: if (s_axi_bready) wrState_d = WrIdle;
         default: wrState_d = WrIdle;
      endcase
      case (rdState_q)
         RdIdle:  if (rdAccept) rdState_d = RdRresp;
         RdRresp: if (s_axi_rready) rdState_d = RdIdle;
         default: rdState_d = RdIdle;
      endcase
   end

   // Register updates happen on the accept edge; the launch waits for the B handshake.
   always_comb begin
      awready_d    = wrAccept;
      arready_d    = rdAccept;
      bresp_d      = bresp_q;
      rdata_d      = rdata_q;
      rresp_d      = rresp_q;
      cfgM_d       = cfgM_q;
      cfgK_d       = cfgK_q;
      cfgN_d       = cfgN_q;
      startPend_d  = startPend_q;
      start_d      = 1'b0;
      doneSticky_d = doneSticky_q;
      busy_d       = busy_q;
      rdVal        = '0;

      if (wrAccept) begin
         bresp_d = isValidOff(wrOff) ? RespOkay : RespInvalid;
         case (wrOff)
            OffCtrl: if (s_axi_wdata[0]) startPend_d = 1'b1;
            OffCfgM: cfgM_d = s_axi_wdata[31:0];
            OffCfgK: cfgK_d = s_axi_wdata[31:0];
            OffCfgN: cfgN_d = s_axi_wdata[31:0];
            default: ;
         endcase
      end

      if (bHandshake && startPend_q) begin
         start_d      = 1'b1;
         startPend_d  = 1'b0;
         busy_d       = 1'b1;
         doneSticky_d = 1'b0;
      end

      // A completion on the launch edge still leaves DONE set.
      if (done) begin
         doneSticky_d = 1'b1;
         busy_d       = 1'b0;
      end

      if (rdAccept) begin
         rresp_d = isValidOff(rdOff) ? RespOkay : RespInvalid;
         case (rdOff)
            OffStatus: rdVal = {30'd0, busy_q, doneSticky_q};
            OffCfgM:   rdVal = cfgM_q;
            OffCfgK:   rdVal = cfgK_q;
            OffCfgN:   rdVal = cfgN_q;
            default:   rdVal = '0;
         endcase
         rdata_d = DATA_W'(rdVal);
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = awready_q;
   assign s_axi_bvalid  = (wrState_q == WrBresp);
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = (rdState_q == RdRresp);
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign cfg_m         = cfgM_q;
   assign cfg_k         = cfgK_q;
   assign cfg_n         = cfgN_q;
   assign start         = start_q;

endmodule

// File: tb/tb_axi_lite_ctrl_wrapper.sv
// Self-checking bench for axi_lite_ctrl_wrapper: vector table, hand-written corner sequences
// and a randomized phase checked against a register-map model.
module tb_axi_lite_ctrl_wrapper;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
`ifdef AXI_SLVERR_EN
   localparam logic [1:0] RespInvalid = 2'b10;
`else
   localparam logic [1:0] RespInvalid = 2'b00;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] s_axi_awaddr = '0;
   logic              s_axi_awvalid = 1'b0;
   logic              s_axi_awready;
   logic [DATA_W-1:0] s_axi_wdata = '0;
   logic              s_axi_wvalid = 1'b0;
   logic              s_axi_wready;
   logic              s_axi_bvalid;
   logic [1:0]        s_axi_bresp;
   logic              s_axi_bready = 1'b0;
   logic [ADDR_W-1:0] s_axi_araddr = '0;
   logic              s_axi_arvalid = 1'b0;
   logic              s_axi_arready;
   logic [DATA_W-1:0] s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rvalid;
   logic              s_axi_rready = 1'b0;
   logic [31:0]       cfg_m, cfg_k, cfg_n;
   logic              start;
   logic              done = 1'b0;

   always #5 clk = ~clk;

   axi_lite_ctrl_wrapper #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bresp(s_axi_bresp), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready),
      .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n), .start(start), .done(done)
   );

   typedef struct {
      bit                isWrite;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [31:0]       expData;
      logic [1:0]        expResp;
   } vec_t;

   vec_t        vecs[14];
   int          checkCount = 0;
   int          failCount = 0;
   logic [1:0]  resp;
   logic        st;
   logic [31:0] rd;

   // Register-map model used by the randomized phase
   logic [31:0] mCfg[3];
   logic        mDone, mBusy;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      checkCount++;
      failCount++;
      $display("[TB] FAIL %s: timed out waiting for handshake", name);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge; returns the response and the start level seen after the B handshake.
   task automatic axiWrite(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           output logic [1:0] r, output logic startSeen);
      int n;
      s_axi_awaddr  = addr;
      s_axi_wdata   = data;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!s_axi_awready && n < 20);
      if (!s_axi_awready) timeoutFail("write accept");
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      n = 0;
      while (!s_axi_bvalid && n < 20) begin tick(); n++; end
      if (!s_axi_bvalid) timeoutFail("write bvalid");
      r = s_axi_bresp;
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      startSeen = start;
   endtask

   task automatic axiRead(input logic [ADDR_W-1:0] addr, output logic [31:0] data, output logic [1:0] r);
      int n;
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!s_axi_arready && n < 20);
      if (!s_axi_arready) timeoutFail("read accept");
      s_axi_arvalid = 1'b0;
      n = 0;
      while (!s_axi_rvalid && n < 20) begin tick(); n++; end
      if (!s_axi_rvalid) timeoutFail("read rvalid");
      data = s_axi_rdata[31:0];
      r    = s_axi_rresp;
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
   endtask

   task automatic pulseDone();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic applyStimulus();
      logic [7:0]  off;
      logic [31:0] data, expData;
      logic [ADDR_W-1:0] addr;
      logic [7:0]  offs[8];
      bit          valid;
      int          op;
      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h0A, 8'h14, 8'h02};
      for (int i = 0; i < 3; i++) mCfg[i] = '0;
      mDone = 1'b0;
      mBusy = 1'b0;
      for (int i = 0; i < 80; i++) begin
         op   = $urandom_range(0, 9);
         off  = offs[$urandom_range(0, 7)];
         addr = ($urandom() & 32'hFFFF_FF00) | {24'd0, off};
         data = $urandom();
         valid = (off == 8'h00) || (off == 8'h04) || (off == 8'h08) || (off == 8'h0C) || (off == 8'h10);
         if (op < 4) begin
            axiWrite(addr, data, resp, st);
            if (off == 8'h08) mCfg[0] = data;
            if (off == 8'h0C) mCfg[1] = data;
            if (off == 8'h10) mCfg[2] = data;
            checkOutput($sformatf("rand%0d bresp", i), resp, valid ? 2'b00 : RespInvalid);
            checkOutput($sformatf("rand%0d start", i), st, (off == 8'h00) && data[0]);
            if ((off == 8'h00) && data[0]) begin
               mDone = 1'b0;
               mBusy = 1'b1;
            end
            checkOutput($sformatf("rand%0d cfg_m", i), cfg_m, mCfg[0]);
            checkOutput($sformatf("rand%0d cfg_k", i), cfg_k, mCfg[1]);
            checkOutput($sformatf("rand%0d cfg_n", i), cfg_n, mCfg[2]);
         end else if (op < 8) begin
            axiRead(addr, rd, resp);
            case (off)
               8'h04:   expData = {30'd0, mBusy, mDone};
               8'h08:   expData = mCfg[0];
               8'h0C:   expData = mCfg[1];
               8'h10:   expData = mCfg[2];
               default: expData = 32'd0;
            endcase
            checkOutput($sformatf("rand%0d rdata off %02h", i, off), rd, expData);
            checkOutput($sformatf("rand%0d rresp", i), resp, valid ? 2'b00 : RespInvalid);
         end else begin
            pulseDone();
            mDone = 1'b1;
            mBusy = 1'b0;
         end
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      vecs[0]  = '{1'b1, 32'h0000_0008, 32'd4,  32'd0, 2'b00};
      vecs[1]  = '{1'b1, 32'h0000_000C, 32'd5,  32'd0, 2'b00};
      vecs[2]  = '{1'b1, 32'h0000_0010, 32'd6,  32'd0, 2'b00};
      vecs[3]  = '{1'b0, 32'h0000_0008, 32'd0,  32'd4, 2'b00};
      vecs[4]  = '{1'b0, 32'h0000_000C, 32'd0,  32'd5, 2'b00};
      vecs[5]  = '{1'b0, 32'h0000_0010, 32'd0,  32'd6, 2'b00};
      vecs[6]  = '{1'b1, 32'h0000_000A, 32'd7,  32'd0, RespInvalid};
      vecs[7]  = '{1'b0, 32'h0000_000A, 32'd0,  32'd0, RespInvalid};
      vecs[8]  = '{1'b1, 32'h0000_0004, 32'd1,  32'd0, 2'b00};
      vecs[9]  = '{1'b0, 32'h0000_0004, 32'd0,  32'd0, 2'b00};
      vecs[10] = '{1'b0, 32'h0000_0000, 32'd0,  32'd0, 2'b00};
      vecs[11] = '{1'b0, 32'h0000_0108, 32'd0,  32'd4, 2'b00};
      vecs[12] = '{1'b1, 32'hFF00_0014, 32'h99, 32'd0, RespInvalid};
      vecs[13] = '{1'b0, 32'h0000_0008, 32'd0,  32'd4, 2'b00};

      // Reset state
      #12;
      checkOutput("reset awready", s_axi_awready, 0);
      checkOutput("reset bvalid", s_axi_bvalid, 0);
      checkOutput("reset rvalid", s_axi_rvalid, 0);
      checkOutput("reset start", start, 0);
      checkOutput("reset cfg_m", cfg_m, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].isWrite) begin
            axiWrite(vecs[i].addr, vecs[i].wdata, resp, st);
            checkOutput($sformatf("vec%0d bresp", i), resp, vecs[i].expResp);
            checkOutput($sformatf("vec%0d start", i), st, 0);
         end else begin
            axiRead(vecs[i].addr, rd, resp);
            checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expData);
            checkOutput($sformatf("vec%0d rresp", i), resp, vecs[i].expResp);
         end
      end
      checkOutput("table cfg_m", cfg_m, 4);
      checkOutput("table cfg_k", cfg_k, 5);
      checkOutput("table cfg_n", cfg_n, 6);

      // Launch, status and sticky done
      axiWrite(32'h0, 32'h1, resp, st);
      checkOutput("launch start", st, 1);
      tick();
      checkOutput("launch start one cycle", start, 0);
      axiRead(32'h4, rd, resp);
      checkOutput("status busy", rd, 32'h2);
      pulseDone();
      axiRead(32'h4, rd, resp);
      checkOutput("status done", rd, 32'h1);
      axiWrite(32'h0, 32'h1, resp, st);
      checkOutput("relaunch start", st, 1);
      axiRead(32'h4, rd, resp);
      checkOutput("status done cleared", rd, 32'h2);
      axiWrite(32'h0, 32'h0, resp, st);
      checkOutput("ctrl bit0=0 no start", st, 0);
      axiRead(32'h4, rd, resp);
      checkOutput("ctrl bit0=0 status", rd, 32'h2);

      // Address without data must wait
      s_axi_awaddr  = 32'h8;
      s_axi_wdata   = 32'd9;
      s_axi_awvalid = 1'b1;
      repeat (3) tick();
      checkOutput("aw only awready", s_axi_awready, 0);
      checkOutput("aw only bvalid", s_axi_bvalid, 0);
      checkOutput("aw only cfg_m", cfg_m, 4);
      s_axi_wvalid = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!s_axi_awready && n < 20);
      if (!s_axi_awready) timeoutFail("aw+w accept");
      checkOutput("aw+w wready", s_axi_wready, 1);
      checkOutput("aw+w cfg_m", cfg_m, 9);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      tick();
      checkOutput("awready one cycle", s_axi_awready, 0);
      repeat (2) tick();
      checkOutput("bvalid holds", s_axi_bvalid, 1);
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      checkOutput("bvalid released", s_axi_bvalid, 0);

      // rvalid/rdata hold; arvalid during RRESP ignored
      s_axi_araddr  = 32'hC;
      s_axi_arvalid = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!s_axi_arready && n < 20);
      if (!s_axi_arready) timeoutFail("hold read accept");
      s_axi_araddr = 32'h10;
      repeat (3) tick();
      checkOutput("rvalid holds", s_axi_rvalid, 1);
      checkOutput("rdata holds", s_axi_rdata, 5);
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      checkOutput("rvalid released", s_axi_rvalid, 0);

      // done on the launch edge keeps DONE set
      s_axi_awaddr  = 32'h0;
      s_axi_wdata   = 32'h1;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!s_axi_awready && n < 20);
      if (!s_axi_awready) timeoutFail("collision accept");
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b1;
      done          = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      done         = 1'b0;
      checkOutput("collision start", start, 1);
      axiRead(32'h4, rd, resp);
      checkOutput("collision done wins", rd & 32'h1, 32'h1);

      // Reset with a launch write pending in BRESP
      s_axi_awaddr  = 32'h0;
      s_axi_wdata   = 32'h1;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!s_axi_awready && n < 20);
      if (!s_axi_awready) timeoutFail("reset-case accept");
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      checkOutput("pre-reset bvalid", s_axi_bvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid reset bvalid", s_axi_bvalid, 0);
      checkOutput("mid reset start", start, 0);
      checkOutput("mid reset cfg_m", cfg_m, 0);
      checkOutput("mid reset cfg_k", cfg_k, 0);
      checkOutput("mid reset cfg_n", cfg_n, 0);
      @(negedge clk);
      rst_n        = 1'b1;
      s_axi_bready = 1'b1;
      tick();
      checkOutput("post reset start", start, 0);
      s_axi_bready = 1'b0;
      axiRead(32'h4, rd, resp);
      checkOutput("post reset status", rd, 0);

      applyStimulus();

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
